// File: rtl/mac_vec_sequencer.sv
// ============================================================================
//  Module      : mac_vec_sequencer
//  Description : Initiator side of the mac_cell operand interface. Accepts a
//                stream of (a,b) operand beats over valid/ready, drives one
//                external mac_cell and chains its acc_out back into acc_in.
//                Emits one dot-product result per vector over valid/ready.
//
//  Ports
//    clk          in   1      clock, all state updates on rising edge
//    rst          in   1      synchronous reset, active low (0 = reset)
//    in_valid     in   1      operand beat valid
//    in_ready     out  1      sequencer can accept a beat
//    in_a         in   A_W    operand a
//    in_b         in   A_W    operand b
//    in_last      in   1      beat is the final element of the vector
//    mac_a        out  A_W    to mac_cell.a (registered)
//    mac_b        out  A_W    to mac_cell.b (registered)
//    mac_acc_in   out  ACC_W  to mac_cell.acc_in (combinational mux)
//    mac_acc_out  in   ACC_W  from mac_cell.acc_out
//    res_valid    out  1      result valid (registered)
//    res_ready    in   1      result consumer ready
//    res_data     out  ACC_W  dot product (mac_acc_out while res_valid)
//    res_count    out  CNT_W  accepted elements in the vector, saturating
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_vec_sequencer #(
    parameter int A_W   = 16,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [A_W-1:0]   in_b,
    input  logic             in_last,
    output logic [A_W-1:0]   mac_a,
    output logic [A_W-1:0]   mac_b,
    output logic [ACC_W-1:0] mac_acc_in,
    input  logic [ACC_W-1:0] mac_acc_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0] res_count
);

    typedef enum logic [1:0] {
        S_ACCUM  = 2'd0,
        S_DRAIN  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_first;      // next presented element starts a new sum
    logic             r_issued;     // a beat is on mac_a/mac_b this cycle
    logic             r_res_valid;
    logic [A_W-1:0]   r_mac_a;
    logic [A_W-1:0]   r_mac_b;
    logic [CNT_W-1:0] r_count;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_res_take;

    // Next-state and handshake decode. in_ready is gated by rst directly so
    // that nothing is accepted while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            S_ACCUM: begin
                w_in_ready = rst;
                if (in_valid && rst && in_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            default: begin
                w_state_nxt = S_ACCUM;
            end
        endcase
    end

    assign w_accept   = in_valid && w_in_ready;
    assign w_res_take = (r_state == S_RESULT) && res_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_ACCUM;
            r_first     <= 1'b1;
            r_issued    <= 1'b0;
            r_res_valid <= 1'b0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_res_valid <= (w_state_nxt == S_RESULT);
            r_issued    <= w_accept;

            // Non-accept cycles present zero operands, so the MAC just
            // recirculates its sum.
            if (w_accept) begin
                r_mac_a <= in_a;
                r_mac_b <= in_b;
                if (r_count != c_CNT_MAX) begin
                    r_count <= r_count + 1'b1;
                end
            end else begin
                r_mac_a <= '0;
                r_mac_b <= '0;
            end

            // first stays set through the cycle the first element sits on
            // the MAC inputs, so that element is added to zero rather than
            // to whatever acc_out held from the previous vector.
            if (w_res_take) begin
                r_first <= 1'b1;
                r_count <= '0;
            end else if (r_issued) begin
                r_first <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign mac_a      = r_mac_a;
    assign mac_b      = r_mac_b;
    assign mac_acc_in = r_first ? '0 : mac_acc_out;
    assign res_valid  = r_res_valid;
    assign res_data   = mac_acc_out;
    assign res_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mac_vec_sequencer.sv
// ============================================================================
//  Module      : tb_mac_vec_sequencer
//  Description : Self-checking bench for mac_vec_sequencer. Two instances
//                (CNT_W=8 and CNT_W=2) share one stimulus stream, each with
//                its own behavioural mac_cell. A transaction-level model
//                predicts every output each cycle; directed vectors pin the
//                model with hand-computed results.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_vec_sequencer;

    localparam int A_W   = 16;
    localparam int ACC_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [A_W-1:0]   in_a;
    logic [A_W-1:0]   in_b;
    logic             in_last;
    logic             res_ready;

    logic             in_ready1, in_ready2;
    logic [A_W-1:0]   mac_a1, mac_b1, mac_a2, mac_b2;
    logic [ACC_W-1:0] acc_in1, acc_in2;
    logic [ACC_W-1:0] acc_out1 = 32'hDEAD_BEEF;
    logic [ACC_W-1:0] acc_out2 = 32'h1234_5678;
    logic             res_valid1, res_valid2;
    logic [ACC_W-1:0] res_data1, res_data2;
    logic [7:0]       res_count1;
    logic [1:0]       res_count2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_vec_sequencer #(.A_W(A_W), .ACC_W(ACC_W), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mac_a(mac_a1), .mac_b(mac_b1), .mac_acc_in(acc_in1), .mac_acc_out(acc_out1),
        .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1),
        .res_count(res_count1)
    );

    mac_vec_sequencer #(.A_W(A_W), .ACC_W(ACC_W), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mac_a(mac_a2), .mac_b(mac_b2), .mac_acc_in(acc_in2), .mac_acc_out(acc_out2),
        .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
        .res_count(res_count2)
    );

    // Behavioural mac_cells: acc_out <= acc_in + a*b, no reset.
    always @(posedge clk) acc_out1 <= acc_in1 + 32'(mac_a1) * 32'(mac_b1);
    always @(posedge clk) acc_out2 <= acc_in2 + 32'(mac_a2) * 32'(mac_b2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // psum: sum of products accepted in the current vector.
    // last_*: the beat accepted at the latest edge (now on the MAC inputs).
    // busy/age: a vector is closed; result is due one edge after closing.
    bit          m_started = 1'b0;
    bit          m_busy    = 1'b0;
    int          m_age     = 0;
    int          m_cnt     = 0;
    logic [31:0] m_psum      = '0;
    logic [31:0] m_last_prod = '0;
    logic [15:0] m_last_a    = '0;
    logic [15:0] m_last_b    = '0;
    bit          m_acc;

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            m_started = 1'b1; m_busy = 1'b0; m_age = 0; m_cnt = 0;
            m_psum = '0; m_last_prod = '0; m_last_a = '0; m_last_b = '0;
        end else begin
            m_acc = in_valid && !m_busy;
            if (m_busy) begin
                if (m_age >= 1 && res_ready) begin
                    m_busy = 1'b0; m_psum = '0; m_cnt = 0;
                end else begin
                    m_age++;
                end
            end
            if (m_acc) begin
                m_last_prod = 32'(in_a) * 32'(in_b);
                m_psum      = m_psum + m_last_prod;
                m_last_a    = in_a;
                m_last_b    = in_b;
                m_cnt++;
                if (in_last) begin
                    m_busy = 1'b1; m_age = 0;
                end
            end else begin
                m_last_prod = '0; m_last_a = '0; m_last_b = '0;
            end
        end
    end

    task automatic cmp_dut(input string nm, input logic rdy, input logic rv,
                           input logic [31:0] data, input int count,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] ain, input int cmax);
        bit erv;
        erv = m_busy && (m_age >= 1);
        chk({nm, ".in_ready"},   32'(rdy), 32'(rst && !m_busy));
        chk({nm, ".res_valid"},  32'(rv),  32'(erv));
        chk({nm, ".mac_a"},      32'(a),   32'(m_last_a));
        chk({nm, ".mac_b"},      32'(b),   32'(m_last_b));
        chk({nm, ".mac_acc_in"}, ain,      m_psum - m_last_prod);
        if (erv) begin
            chk({nm, ".res_data"},  data,      m_psum);
            chk({nm, ".res_count"}, 32'(count), 32'((m_cnt > cmax) ? cmax : m_cnt));
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (m_started) begin
            cmp_dut("dut8", in_ready1, res_valid1, res_data1, 32'(res_count1),
                    mac_a1, mac_b1, acc_in1, 255);
            cmp_dut("dut2", in_ready2, res_valid2, res_data2, 32'(res_count2),
                    mac_a2, mac_b2, acc_in2, 3);
        end
    end

    // ---------------- stimulus helpers ----------------
    // All tasks start and end at posedge+1.
    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        int   g;
        logic rdy;
        g = 0; rdy = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        while (!rdy && g < 50) begin
            @(negedge clk); rdy = in_ready1;
            @(posedge clk); #1; g++;
        end
        chk("beat.accepted", 32'(rdy), 32'd1);
        in_valid = 1'b0; in_last = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Wait for a result, check it against literals, optionally stall, release.
    task automatic get_result(input logic [31:0] ed, input int ec8, input int ec2, input int stall);
        int g;
        g = 0;
        res_ready = 1'b0;
        @(negedge clk);
        while (!res_valid1 && g < 40) begin
            @(negedge clk); g++;
        end
        chk("lit.res_valid",   32'(res_valid1), 32'd1);
        chk("lit.res_data",    res_data1,       ed);
        chk("lit.res_count8",  32'(res_count1), 32'(ec8));
        chk("lit.res_count2",  32'(res_count2), 32'(ec2));
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            chk("lit.stall_valid",    32'(res_valid1), 32'd1);
            chk("lit.stall_data",     res_data1,       ed);
            chk("lit.stall_in_ready", 32'(in_ready1),  32'd0);
        end
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    // Random consumer: res_ready and junk in_valid toggle until the handshake.
    task automatic rand_release();
        int g;
        bit done;
        g = 0; done = 1'b0;
        while (!done && g < 60) begin
            res_ready = ($urandom_range(0, 2) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_last   = 1'($urandom_range(0, 1));
            in_a = 16'($urandom); in_b = 16'($urandom);
            @(negedge clk); done = res_valid1 && res_ready;
            @(posedge clk); #1; g++;
        end
        chk("rand.handshake", 32'(done), 32'd1);
        res_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int len;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; res_ready = 1'b0;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("lit.rst_in_ready",   32'(in_ready1), 32'd0);
        chk("lit.rst_res_valid",  32'(res_valid1), 32'd0);
        chk("lit.rst_mac_a",      32'(mac_a1), 32'd0);
        chk("lit.rst_mac_b",      32'(mac_b1), 32'd0);
        chk("lit.rst_mac_acc_in", acc_in1, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("lit.post_rst_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk); #1;

        // Back-to-back pair; result appears two cycles after the accepting cycle
        beat(16'd3, 16'd4, 1'b0);
        beat(16'd2, 16'd5, 1'b1);
        @(negedge clk);
        chk("lit.latency_drain", 32'(res_valid1), 32'd0);
        @(negedge clk);
        chk("lit.latency_result", 32'(res_valid1), 32'd1);
        get_result(32'd22, 2, 2, 0);

        // Bubbles inside the vector
        beat(16'd3, 16'd4, 1'b0);
        idle(2);
        beat(16'd2, 16'd5, 1'b1);
        get_result(32'd22, 2, 2, 0);

        // Consumer stall, then single-element vector without carry-over
        beat(16'd3, 16'd4, 1'b0);
        beat(16'd2, 16'd5, 1'b1);
        get_result(32'd22, 2, 2, 5);
        beat(16'd7, 16'd9, 1'b1);
        get_result(32'd63, 1, 1, 0);

        // Reset mid-vector discards the partial sum
        beat(16'd100, 16'd100, 1'b0);
        beat(16'd1, 16'd1, 1'b0);
        pulse_reset();
        beat(16'd1, 16'd1, 1'b1);
        get_result(32'd1, 1, 1, 0);

        // Count saturation on the 2-bit instance
        for (int k = 0; k < 5; k++) beat(16'd1, 16'd1, (k == 4));
        get_result(32'd5, 5, 3, 0);

        // Randomized vectors
        for (int v = 0; v < 40; v++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if (k == 1 && $urandom_range(0, 9) == 0) pulse_reset();
                res_ready = 1'($urandom_range(0, 1));
                beat(16'($urandom), 16'($urandom), (k == len - 1));
                if (k != len - 1) idle($urandom_range(0, 2));
            end
            rand_release();
            idle($urandom_range(0, 2));
        end

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
